// File: rtl/wb_stage_if.sv
// wb_stage_if: bundles the MEM->WB instruction fields, the data-memory
// response and the writeback/hazard outputs of the writeback stage.
//   master : the surrounding pipeline (drives m_*, flush_w, dmem_*)
//   slave  : wb_stage (drives writeback_*, rd, wb_stall, load_fault, instret)
interface wb_stage_if #(
  parameter int INSTRET_WIDTH = 64
);
  logic                     m_valid;
  logic                     m_regwrite;
  logic [1:0]               m_result_src;
  logic                     m_is_load;
  logic [2:0]               m_funct3;
  logic [4:0]               m_rd;
  logic [31:0]              m_alu_result;
  logic [31:0]              m_pc_plus_4;
  logic                     flush_w;
  logic                     dmem_rvalid;
  logic [31:0]              dmem_rdata;
  logic                     writeback_control;
  logic [4:0]               rd;
  logic [31:0]              writeback_data;
  logic                     wb_stall;
  logic                     load_fault;
  logic [INSTRET_WIDTH-1:0] instret;

  modport master (
    output m_valid, m_regwrite, m_result_src, m_is_load, m_funct3, m_rd,
           m_alu_result, m_pc_plus_4, flush_w, dmem_rvalid, dmem_rdata,
    input  writeback_control, rd, writeback_data, wb_stall, load_fault, instret
  );

  modport slave (
    input  m_valid, m_regwrite, m_result_src, m_is_load, m_funct3, m_rd,
           m_alu_result, m_pc_plus_4, flush_w, dmem_rvalid, dmem_rdata,
    output writeback_control, rd, writeback_data, wb_stall, load_fault, instret
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the RV32I pipeline.
// Holds the MEM/WB register, waits (bounded) for load data, aligns and
// extends it, selects the result and drives the register-file write port.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high
//   bus   : wb_stage_if.slave -- m_* capture fields, flush_w, dmem_rvalid/
//           dmem_rdata in; writeback_control, rd, writeback_data, wb_stall,
//           load_fault, instret out
// Writeback outputs are combinational from the W register and dmem_*, because
// the decode stage commits the write on the negedge of the same cycle.
module wb_stage #(
  parameter int LOAD_TIMEOUT  = 16,
  parameter int INSTRET_WIDTH = 64
) (
  input  logic     clk,
  input  logic     reset,
  wb_stage_if.slave bus
);

  localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(LOAD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Byte/halfword alignment and extension of a raw load word.
  function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                           input logic [1:0]  off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // W register and FSM state
  logic                     valid_q, valid_d;
  logic                     regwrite_q, regwrite_d;
  logic [1:0]               result_src_q, result_src_d;
  logic                     is_load_q, is_load_d;
  logic [2:0]               funct3_q, funct3_d;
  logic [4:0]               rd_q, rd_d;
  logic [31:0]              alu_q, alu_d;
  logic [31:0]              pcp4_q, pcp4_d;
  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

  logic        need_data_s;
  logic        wb_stall_s;
  logic        load_fault_s;
  logic        retire_s;
  logic [31:0] load_word_s;
  logic [31:0] result_s;

  assign need_data_s = valid_q & is_load_q & (state_q == RUN);

  // Load-wait FSM: stall decision, timeout counting and fault pulse.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wb_stall_s   = 1'b0;
    load_fault_s = 1'b0;
    case (state_q)
      RUN: begin
        if (need_data_s && !bus.dmem_rvalid) begin
          wb_stall_s = 1'b1;
          state_d    = WAIT;
          cnt_d      = CNT_ONE;
        end else begin
          state_d = RUN;
          cnt_d   = CNT_ZERO;
        end
      end
      WAIT: begin
        if (bus.dmem_rvalid) begin
          state_d = RUN;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == TIMEOUT_C) begin
          // Give up on the load: retire it with a zero result.
          load_fault_s = 1'b1;
          state_d      = RUN;
          cnt_d        = CNT_ZERO;
        end else begin
          wb_stall_s = 1'b1;
          cnt_d      = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign retire_s = valid_q & ~wb_stall_s;

  // Result selection and writeback port drive.
  always_comb begin
    load_word_s = load_ext(funct3_q, alu_q[1:0], bus.dmem_rdata);
    case (result_src_q)
      2'b01:   result_s = load_word_s;
      2'b10:   result_s = pcp4_q;
      default: result_s = alu_q;
    endcase
    if (!valid_q || load_fault_s) begin
      bus.writeback_data = 32'h0000_0000;
    end else begin
      bus.writeback_data = result_s;
    end
    bus.writeback_control = retire_s & regwrite_q & (rd_q != 5'd0);
    bus.rd                = rd_q;
    bus.wb_stall          = wb_stall_s;
    bus.load_fault        = load_fault_s;
    bus.instret           = instret_q;
  end

  // W register capture (held while stalled, so flush_w is ignored then).
  always_comb begin
    if (wb_stall_s) begin
      valid_d      = valid_q;
      regwrite_d   = regwrite_q;
      result_src_d = result_src_q;
      is_load_d    = is_load_q;
      funct3_d     = funct3_q;
      rd_d         = rd_q;
      alu_d        = alu_q;
      pcp4_d       = pcp4_q;
    end else begin
      valid_d      = bus.m_valid & ~bus.flush_w;
      regwrite_d   = bus.m_regwrite;
      result_src_d = bus.m_result_src;
      is_load_d    = bus.m_is_load;
      funct3_d     = bus.m_funct3;
      rd_d         = bus.m_rd;
      alu_d        = bus.m_alu_result;
      pcp4_d       = bus.m_pc_plus_4;
    end
    instret_d = instret_q + INSTRET_WIDTH'(retire_s);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      result_src_q <= 2'b00;
      is_load_q    <= 1'b0;
      funct3_q     <= 3'b000;
      rd_q         <= 5'd0;
      alu_q        <= 32'h0000_0000;
      pcp4_q       <= 32'h0000_0000;
      state_q      <= RUN;
      cnt_q        <= CNT_ZERO;
      instret_q    <= {INSTRET_WIDTH{1'b0}};
    end else begin
      valid_q      <= valid_d;
      regwrite_q   <= regwrite_d;
      result_src_q <= result_src_d;
      is_load_q    <= is_load_d;
      funct3_q     <= funct3_d;
      rd_q         <= rd_d;
      alu_q        <= alu_d;
      pcp4_q       <= pcp4_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      instret_q    <= instret_d;
    end
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final (writeback) stage of the pipelined RV32I core.
- Holds the MEM/WB pipeline register and waits for load data from the data memory.
- Aligns and extends load data, then selects the result.
- Drives the register-file write port of the decode stage: writeback_control, rd, writeback_data. The decode stage commits that write on the negedge of the same cycle.
- Also provides forwarding data, a stall request, a load-timeout fault and the retired-instruction counter.

Parameters:
- LOAD_TIMEOUT, 16: cycles to wait for dmem_rvalid before declaring a load fault. Must be >= 1.
- INSTRET_WIDTH, 64: width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- m_valid  in  1  MEM stage holds a real instruction.
- m_regwrite  in  1  instruction writes rd.
- m_result_src  in  2  result select: 00 ALU, 01 load, 10 pc+4, 11 ALU.
- m_is_load  in  1  instruction is a load.
- m_funct3  in  3  load type.
- m_rd  in  5  destination register.
- m_alu_result  in  32  ALU result; also the load address (bits [1:0] give the byte offset).
- m_pc_plus_4  in  32  link value.
- flush_w  in  1  squash the instruction being captured.
- dmem_rvalid  in  1  load data valid this cycle.
- dmem_rdata  in  32  raw load word.
- writeback_control  out  1  register-file write enable.
- rd  out  5  write address.
- writeback_data  out  32  write data.
- wb_stall  out  1  stall request to the hazard unit; must freeze all earlier stages.
- load_fault  out  1  one-cycle pulse when a load times out.
- instret  out  INSTRET_WIDTH  retired-instruction count.

Behaviour:
- W register contents (valid_q, regwrite_q, result_src_q, is_load_q, funct3_q, rd_q, alu_q, pcp4_q):
  - Loads from the m_* inputs on posedge clk when wb_stall=0.
  - If flush_w=1 at capture, valid_q<=0 and the other fields are don't-care.
  - Holds while wb_stall=1.
- Reset (async): all W fields 0; FSM to RUN; wait counter 0; instret 0.
  - Outputs after reset: writeback_control=0, rd=0, writeback_data=0, wb_stall=0, load_fault=0.
- Load pending: need_data = valid_q & is_load_q & (state==RUN).
- FSM, RUN state:
  - need_data & !dmem_rvalid: wb_stall=1, go to WAIT, wait counter <= 1.
  - need_data & dmem_rvalid: no stall; retire this cycle using dmem_rdata.
  - Otherwise: retire with no stall.
- FSM, WAIT state (wb_stall=1 throughout):
  - dmem_rvalid=1: retire this cycle using dmem_rdata, wb_stall=0 this cycle, go to RUN. The W register loads the next instruction at this edge.
  - Else, when the counter reaches LOAD_TIMEOUT: load_fault=1 for one cycle, retire with writeback_data=0, wb_stall=0, go to RUN.
  - Else: counter increments.
- dmem_rvalid is ignored when no load is pending. Asserting it in that case is a protocol error with no effect.
- Load extension uses off = alu_q[1:0]:
  - funct3 000 (lb): byte at off, sign-extended.
  - funct3 100 (lbu): byte at off, zero-extended.
  - funct3 001 (lh) / 101 (lhu): halfword selected by off[1], sign- / zero-extended; off[0] ignored.
  - funct3 010 and 011/110/111: full word.
- Result select: 00 → alu_q; 01 → extended load; 10 → pcp4_q; 11 → alu_q.
- Retire (per cycle, combinational):
  - retire = valid_q & !(wb_stall).
  - writeback_control = retire & regwrite_q & (rd_q != 0).
  - rd = rd_q.
  - writeback_data = selected result. It is 0 when valid_q=0; otherwise it is driven even if writeback_control=0.
- instret: increments by 1 on posedge clk when retire=1, including faulted loads. Wraps modulo 2^INSTRET_WIDTH.
- Flush while stalled: flush_w is ignored while wb_stall=1, because a load in WB is committed.
- Reset mid-WAIT: immediately returns to RUN with W cleared. A dmem_rvalid arriving after reset is ignored.

Test Plan:
1. ALU op: m_valid=1, regwrite=1, result_src=00, rd=5, alu=0x1234 → next cycle writeback_control=1, rd=5, writeback_data=0x1234, instret 0→1.
2. Zero-latency lb: alu=0x...02, dmem_rdata=0x00800000 with dmem_rvalid in the same cycle → writeback_data=0xFFFFFF80, wb_stall=0. With lbu and the same data → 0x00000080.
3. Delayed load: lh, off=2, rdata=0xBEEF0000, rvalid 3 cycles late → wb_stall=1 for 3 cycles, no write; then writeback_data=0xFFFFBEEF; next instruction captured on the same edge; instret +1 only.
4. Timeout: LOAD_TIMEOUT=4, load with no rvalid → wb_stall for 4 cycles, load_fault pulses once, write of 0 to rd, return to RUN.
5. rd=0 / flush: regwrite=1 with rd=0 → writeback_control=0 but instret increments. flush_w=1 at capture → valid_q=0, no write, no increment.
6. Async reset asserted in WAIT → wb_stall=0, instret=0 immediately. A later dmem_rvalid causes no write.
